// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the scalar MEM stage (S) and the vector unit (V).
// Optional feature: define DMEM_ARB_RR_EN for round-robin conflict resolution (default: V has fixed priority).
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_s_req,
  input  logic          i_s_we,
  input  logic [AW-1:0] i_s_addr,
  input  logic [DW-1:0] i_s_wdata,
  output logic          o_s_gnt,
  output logic          o_s_rvalid,
  output logic [DW-1:0] o_s_rdata,
  output logic          o_s_stall,
  input  logic          i_v_req,
  input  logic          i_v_we,
  input  logic [AW-1:0] i_v_addr,
  input  logic [DW-1:0] i_v_wdata,
  input  logic          i_v_lock,
  output logic          o_v_gnt,
  output logic          o_v_rvalid,
  output logic [DW-1:0] o_v_rdata,
  output logic          o_m_req,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic          i_m_ack,
  input  logic          i_m_rvalid,
  input  logic [DW-1:0] i_m_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RD} state_e;

  state_e          state_q, state_d;
  logic            owner_v_q, owner_v_d;
  logic            last_v_q, last_v_d;
  logic            lock_q, lock_d;
  logic            m_we_q, m_we_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;

  logic            win_s, win_v;
  logic            accept, deliver;

  // Grant decision: an active lock reserves the port for V even when V is idle.
  always_comb begin
    win_s = 1'b0;
    win_v = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (lock_q && i_v_lock) begin
        win_v = i_v_req;
      end else if (i_s_req && i_v_req) begin
`ifdef DMEM_ARB_RR_EN
        win_s = last_v_q;
        win_v = ~last_v_q;
`else
        win_v = 1'b1;
`endif
      end else begin
        win_s = i_s_req;
        win_v = i_v_req;
      end
    end
  end

  assign accept  = (state_q == REQ) && i_m_ack;
  assign deliver = !rst && i_m_rvalid &&
                   ((accept && !m_we_q) || (state_q == RD));

  always_comb begin
    state_d   = state_q;
    owner_v_d = owner_v_q;
    last_v_d  = last_v_q;
    lock_d    = lock_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (!i_v_lock) lock_d = 1'b0;
        if (win_v) begin
          state_d   = REQ;
          owner_v_d = 1'b1;
          last_v_d  = 1'b1;
          lock_d    = i_v_lock;
          m_we_d    = i_v_we;
          m_addr_d  = i_v_addr;
          m_wdata_d = i_v_wdata;
        end else if (win_s) begin
          state_d   = REQ;
          owner_v_d = 1'b0;
          last_v_d  = 1'b0;
          m_we_d    = i_s_we;
          m_addr_d  = i_s_addr;
          m_wdata_d = i_s_wdata;
        end
      end
      REQ: begin
        if (accept) begin
          if (m_we_q || i_m_rvalid) state_d = IDLE;
          else                      state_d = RD;
        end
      end
      RD: begin
        if (i_m_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_v_q <= 1'b1;
      last_v_q  <= 1'b1;
      lock_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_v_q <= owner_v_d;
      last_v_q  <= last_v_d;
      lock_q    <= lock_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign o_s_gnt    = win_s;
  assign o_v_gnt    = win_v;
  assign o_m_req    = (state_q == REQ);
  assign o_m_we     = m_we_q;
  assign o_m_addr   = m_addr_q;
  assign o_m_wdata  = m_wdata_q;

  // Read data is a combinational pass-through steered to the transaction owner.
  assign o_s_rvalid = deliver && !owner_v_q;
  assign o_v_rvalid = deliver && owner_v_q;
  assign o_s_rdata  = owner_v_q ? '0 : i_m_rdata;
  assign o_v_rdata  = owner_v_q ? i_m_rdata : '0;

  assign o_s_stall  = (i_s_req && !o_s_gnt) ||
                      ((state_q != IDLE) && !owner_v_q &&
                       !(o_s_rvalid || (accept && m_we_q)));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the shared memory port.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_req, s_we, v_req, v_we, v_lock, m_ack, m_rvalid;
  logic [AW-1:0] s_addr, v_addr;
  logic [DW-1:0] s_wdata, v_wdata, m_rdata;
  logic          s_gnt, s_rvalid, s_stall, v_gnt, v_rvalid, m_req, m_we;
  logic [DW-1:0] s_rdata, v_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  int n_vec  = 0;
  int n_fail = 0;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_s_req(s_req), .i_s_we(s_we), .i_s_addr(s_addr), .i_s_wdata(s_wdata),
    .o_s_gnt(s_gnt), .o_s_rvalid(s_rvalid), .o_s_rdata(s_rdata), .o_s_stall(s_stall),
    .i_v_req(v_req), .i_v_we(v_we), .i_v_addr(v_addr), .i_v_wdata(v_wdata),
    .i_v_lock(v_lock),
    .o_v_gnt(v_gnt), .o_v_rvalid(v_rvalid), .o_v_rdata(v_rdata),
    .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_ack(m_ack), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata)
  );

  initial forever #5 clk = ~clk;

  // Transaction-level model: one in-flight transaction described by who owns it,
  // what it is, and whether memory has already taken the command.
  bit            t_busy, t_taken, t_by_v, last_by_v, reserved;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  bit            e_sg, e_vg, e_sr, e_vr, e_stall, e_mreq;

  task automatic model_reset();
    t_busy = 0; t_taken = 0; t_by_v = 1; last_by_v = 1; reserved = 0;
    t_we = 0; t_addr = '0; t_wdata = '0;
  endtask

  task automatic model_expect();
    bit data_now;
    e_sg = 0; e_vg = 0;
    if (!rst && !t_busy) begin
      if (reserved && v_lock) e_vg = v_req;
      else if (s_req && v_req) begin
`ifdef DMEM_ARB_RR_EN
        e_vg = !last_by_v;
        e_sg = last_by_v;
`else
        e_vg = 1;
`endif
      end else begin
        e_sg = s_req; e_vg = v_req;
      end
    end
    data_now = !rst && t_busy && !t_we && m_rvalid && (t_taken || m_ack);
    e_sr     = data_now && !t_by_v;
    e_vr     = data_now && t_by_v;
    e_mreq   = t_busy && !t_taken;
    e_stall  = (s_req && !e_sg) ||
               (t_busy && !t_by_v && !(e_sr || (!t_taken && m_ack && t_we)));
  endtask

  task automatic model_step();
    if (!t_busy) begin
      if (!v_lock) reserved = 0;
      if (e_vg) begin
        t_busy = 1; t_taken = 0; t_by_v = 1; last_by_v = 1; reserved = v_lock;
        t_we = v_we; t_addr = v_addr; t_wdata = v_wdata;
      end else if (e_sg) begin
        t_busy = 1; t_taken = 0; t_by_v = 0; last_by_v = 0;
        t_we = s_we; t_addr = s_addr; t_wdata = s_wdata;
      end
    end else if (!t_taken) begin
      if (m_ack) begin
        if (t_we || m_rvalid) t_busy = 0;
        else                  t_taken = 1;
      end
    end else if (m_rvalid) begin
      t_busy = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs are set just after a falling edge; outputs are compared 1 time unit later.
  task automatic settle();
    #1;
    if (rst) model_reset();
    model_expect();
    chk("s_gnt", s_gnt, e_sg);
    chk("v_gnt", v_gnt, e_vg);
    chk("s_rvalid", s_rvalid, e_sr);
    chk("v_rvalid", v_rvalid, e_vr);
    if (e_sr) chk("s_rdata", s_rdata, m_rdata);
    if (e_vr) chk("v_rdata", v_rdata, m_rdata);
    chk("s_stall", s_stall, e_stall);
    chk("m_req", m_req, e_mreq);
    chk("m_we", m_we, t_we);
    chk("m_addr", m_addr, t_addr);
    chk("m_wdata", m_wdata, t_wdata);
  endtask

  task automatic advance();
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic zero_in();
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0; v_lock = 0;
    m_ack = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic do_reset();
    zero_in(); rst = 1; settle(); advance(); rst = 0;
  endtask

  initial begin
    zero_in();
    rst = 1; s_req = 1; v_req = 1;
    settle();
    chk("rst_s_gnt", s_gnt, 0);
    chk("rst_v_gnt", v_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    advance();
    rst = 0;

    // Simultaneous requests twice after reset, zero-wait memory.
    zero_in(); s_req = 1; s_we = 1; s_addr = 32'h10; v_req = 1; v_we = 1; v_addr = 32'h20;
    settle();
`ifdef DMEM_ARB_RR_EN
    chk("conf1_s_gnt", s_gnt, 1); chk("conf1_v_gnt", v_gnt, 0);
`else
    chk("conf1_s_gnt", s_gnt, 0); chk("conf1_v_gnt", v_gnt, 1);
`endif
    advance();
    m_ack = 1; settle(); advance();
    m_ack = 0; s_addr = 32'h14; v_addr = 32'h24; settle();
`ifdef DMEM_ARB_RR_EN
    chk("conf2_s_gnt", s_gnt, 0); chk("conf2_v_gnt", v_gnt, 1);
`else
    chk("conf2_s_gnt", s_gnt, 0); chk("conf2_v_gnt", v_gnt, 1);
    chk("conf2_s_stall", s_stall, 1);
`endif
    advance();
    zero_in(); m_ack = 1; settle(); advance();

    // Scalar read at 0x100, data returns two cycles after the ack.
    do_reset();
    zero_in(); s_req = 1; s_addr = 32'h100; settle();
    chk("t1_gnt", s_gnt, 1); chk("t1_c0_mreq", m_req, 0); advance();
    zero_in(); m_ack = 1; settle();
    chk("t1_c1_mreq", m_req, 1); chk("t1_c1_addr", m_addr, 32'h100); chk("t1_c1_stall", s_stall, 1);
    advance();
    zero_in(); settle();
    chk("t1_c2_mreq", m_req, 0); chk("t1_c2_stall", s_stall, 1); advance();
    zero_in(); m_rvalid = 1; m_rdata = 32'hDEADBEEF; settle();
    chk("t1_c3_rvalid", s_rvalid, 1); chk("t1_c3_rdata", s_rdata, 32'hDEADBEEF);
    chk("t1_c3_stall", s_stall, 0); chk("t1_c3_vrvalid", v_rvalid, 0);
    advance();
    zero_in(); settle(); chk("t1_c4_mreq", m_req, 0); advance();

    // Locked vector write burst while a scalar read waits.
    do_reset();
    zero_in(); v_req = 1; v_we = 1; v_addr = 32'h200; v_wdata = 32'hA0; v_lock = 1; settle();
    chk("t3_vgnt0", v_gnt, 1); advance();
    for (int k = 1; k <= 4; k++) begin
      zero_in(); m_ack = 1; v_lock = 1; s_req = 1; s_addr = 32'h80; settle();
      chk("t3_burst_addr", m_addr, 32'h200 + 32'(4 * (k - 1)));
      chk("t3_sgnt_req", s_gnt, 0); advance();
      if (k < 4) begin
        zero_in(); v_lock = 1; s_req = 1; s_addr = 32'h80;
        v_req = 1; v_we = 1; v_addr = 32'h200 + 32'(4 * k); v_wdata = 32'(k);
        settle();
        chk("t3_vgnt", v_gnt, 1); chk("t3_sgnt_idle", s_gnt, 0); advance();
      end
    end
    zero_in(); s_req = 1; s_addr = 32'h80; settle();
    chk("t3_sgnt_after_unlock", s_gnt, 1); advance();
    zero_in(); m_ack = 1; m_rvalid = 1; m_rdata = 32'hCAFE0001; settle();
    chk("t3_s_rvalid", s_rvalid, 1); advance();

    // Scalar write with the memory stalling for five cycles.
    do_reset();
    zero_in(); s_req = 1; s_we = 1; s_addr = 32'h40; s_wdata = 32'h55; settle();
    chk("t4_gnt", s_gnt, 1); advance();
    for (int c = 1; c <= 5; c++) begin
      zero_in(); settle();
      chk("t4_mreq", m_req, 1); chk("t4_we", m_we, 1);
      chk("t4_addr", m_addr, 32'h40); chk("t4_wdata", m_wdata, 32'h55);
      chk("t4_stall", s_stall, 1); advance();
    end
    zero_in(); m_ack = 1; settle();
    chk("t4_ack_mreq", m_req, 1); chk("t4_ack_stall", s_stall, 0); advance();
    zero_in(); settle(); chk("t4_idle_mreq", m_req, 0); advance();

    // Reset while a vector read waits for data; the late data must not be forwarded.
    do_reset();
    zero_in(); v_req = 1; v_addr = 32'h500; settle(); chk("t5_gnt", v_gnt, 1); advance();
    zero_in(); m_ack = 1; settle(); chk("t5_mreq", m_req, 1); advance();
    zero_in(); rst = 1; settle(); chk("t5_rst_mreq", m_req, 0); advance();
    rst = 0; zero_in(); m_rvalid = 1; m_rdata = 32'h0BAD0BAD; settle();
    chk("t5_late_rvalid", v_rvalid, 0); chk("t5_late_mreq", m_req, 0); advance();

    // Vector read with ack and data in the same cycle, then a new grant.
    do_reset();
    zero_in(); v_req = 1; v_addr = 32'h300; settle(); chk("t6_gnt", v_gnt, 1); advance();
    zero_in(); m_ack = 1; m_rvalid = 1; m_rdata = 32'h12345678; settle();
    chk("t6_rvalid", v_rvalid, 1); chk("t6_rdata", v_rdata, 32'h12345678);
    chk("t6_s_rvalid", s_rvalid, 0); advance();
    zero_in(); s_req = 1; s_addr = 32'h44; settle(); chk("t6_next_gnt", s_gnt, 1); advance();

    // Randomized traffic: requesters hold commands until granted, memory acks and returns data at random.
    do_reset();
    zero_in();
    for (int n = 0; n < 4000; n++) begin
      bit prev_sg, prev_vg;
      prev_sg = e_sg; prev_vg = e_vg;
      if (!s_req || prev_sg) begin
        s_req = ($urandom_range(0, 2) == 0); s_we = 1'($urandom_range(0, 1));
        s_addr = $urandom; s_wdata = $urandom;
      end
      if (!v_req || prev_vg) begin
        v_req = ($urandom_range(0, 2) == 0); v_we = 1'($urandom_range(0, 1));
        v_addr = $urandom; v_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) v_lock = !v_lock;
      m_ack    = 1'($urandom_range(0, 1));
      m_rvalid = ($urandom_range(0, 2) == 0);
      m_rdata  = $urandom;
      rst      = ($urandom_range(0, 299) == 0);
      settle();
      advance();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
